// File: rtl/draw_crate.sv
// draw_crate: two-instance crate sprite renderer on the VGA timing chain.
// Computes 12-bit read addresses for a dual-port 64x64 crate ROM (one-cycle
// registered read), overlays the returned pixels on the incoming stream and
// re-emits the timing bus delayed by 3 cycles so everything stays aligned.
//
// Ports:
//   clk60MHz, rst                          pixel clock, sync active-high reset
//   vcount_in, hcount_in [10:0]            current pixel coordinates
//   vsync_in, vblnk_in, hsync_in, hblnk_in timing strobes
//   rgb_in [11:0]                          background pixel
//   xpos0/ypos0, xpos1/ypos1 [10:0]        crate top-left corners
//   en0, en1                               crate visible
//   address, address1 [11:0]               ROM addresses {row[5:0], col[5:0]}
//   rgb, rgb1 [11:0]                       ROM data, one cycle after address
//   vcount_out, hcount_out, *_out          timing bus delayed 3 cycles
//   rgb_out [11:0]                         composited pixel

// Per-crate lane: frame-latched position shadow, hit test and ROM address.
// Hit flag and address are both registered here (stage 1).
module draw_crate_lane (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_latch,
  input  logic [10:0] i_xpos,
  input  logic [10:0] i_ypos,
  input  logic        i_en,
  input  logic [10:0] i_hcount,
  input  logic [10:0] i_vcount,
  input  logic        i_blank,
  output logic        o_hit,
  output logic [11:0] o_address
);
  logic [10:0] r_x, r_y;
  logic        r_en;
  logic        w_hit;
  logic [5:0]  w_col, w_row;

  // 12-bit compares so x+64 never wraps; off-screen parts are simply never hit
  always_comb begin
    w_hit = r_en && !i_blank
         && ({1'b0, i_hcount} >= {1'b0, r_x}) && ({1'b0, i_hcount} < ({1'b0, r_x} + 12'd64))
         && ({1'b0, i_vcount} >= {1'b0, r_y}) && ({1'b0, i_vcount} < ({1'b0, r_y} + 12'd64));
    // low 6 bits of the difference depend only on the low 6 bits of the operands
    w_col = i_hcount[5:0] - r_x[5:0];
    w_row = i_vcount[5:0] - r_y[5:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_en      <= 1'b0;
      o_hit     <= 1'b0;
      o_address <= '0;
    end else begin
      if (i_latch) begin
        r_x  <= i_xpos;
        r_y  <= i_ypos;
        r_en <= i_en;
      end
      o_hit     <= w_hit;
      o_address <= {w_row, w_col};
    end
  end
endmodule

module draw_crate #(
  parameter logic [11:0] TRANSPARENT_RGB = 12'hF0F,
  parameter bit          USE_KEY         = 1'b1
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic [10:0] vcount_in,
  input  logic [10:0] hcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos0,
  input  logic [10:0] ypos0,
  input  logic [10:0] xpos1,
  input  logic [10:0] ypos1,
  input  logic        en0,
  input  logic        en1,
  output logic [11:0] address,
  output logic [11:0] address1,
  input  logic [11:0] rgb,
  input  logic [11:0] rgb1,
  output logic [10:0] vcount_out,
  output logic [10:0] hcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out
);
  localparam int TBW = 26;  // {vcount, hcount, vsync, vblnk, hsync, hblnk}

  logic           r_vblnk_prev;
  logic           w_latch, w_blank;
  logic [1:0]     w_hit1;
  logic [1:0]     r_hit2;
  logic [TBW-1:0] r_tb1, r_tb2;
  logic [11:0]    r_rgb1, r_rgb2;
  logic           w_op0, w_op1;

  // positions are only taken on the vblank rising edge so a frame never tears
  assign w_latch = vblnk_in && !r_vblnk_prev;
  assign w_blank = hblnk_in || vblnk_in;

  draw_crate_lane u_lane0 (
    .i_clk(clk60MHz), .i_rst(rst), .i_latch(w_latch),
    .i_xpos(xpos0), .i_ypos(ypos0), .i_en(en0),
    .i_hcount(hcount_in), .i_vcount(vcount_in), .i_blank(w_blank),
    .o_hit(w_hit1[0]), .o_address(address)
  );

  draw_crate_lane u_lane1 (
    .i_clk(clk60MHz), .i_rst(rst), .i_latch(w_latch),
    .i_xpos(xpos1), .i_ypos(ypos1), .i_en(en1),
    .i_hcount(hcount_in), .i_vcount(vcount_in), .i_blank(w_blank),
    .o_hit(w_hit1[1]), .o_address(address1)
  );

  assign w_op0 = !USE_KEY || (rgb  != TRANSPARENT_RGB);
  assign w_op1 = !USE_KEY || (rgb1 != TRANSPARENT_RGB);

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      r_vblnk_prev <= 1'b0;
      r_tb1        <= '0;
      r_tb2        <= '0;
      r_rgb1       <= '0;
      r_rgb2       <= '0;
      r_hit2       <= '0;
      {vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out} <= '0;
      rgb_out      <= '0;
    end else begin
      r_vblnk_prev <= vblnk_in;
      // stage 1 (hit flags and addresses live in the lanes)
      r_tb1  <= {vcount_in, hcount_in, vsync_in, vblnk_in, hsync_in, hblnk_in};
      r_rgb1 <= rgb_in;
      // stage 2: ROM data arrives this cycle
      r_tb2  <= r_tb1;
      r_rgb2 <= r_rgb1;
      r_hit2 <= w_hit1;
      // stage 3: composite, crate 0 on top; transparent crate-0 shows crate 1
      {vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out} <= r_tb2;
      if (r_hit2[0] && w_op0)      rgb_out <= rgb;
      else if (r_hit2[1] && w_op1) rgb_out <= rgb1;
      else                         rgb_out <= r_rgb2;
    end
  end
endmodule
